// File: rtl/rv_exec_ctrl_unit.sv
// RV32 decode/execute slice: decoder, ALU, PC adders and branch decision, all outputs registered.
// Optional macro BRANCH_EXT_EN adds bne/bge decoding (inverted branch condition).
module rv_exec_ctrl_unit #(
    parameter int XLEN    = 32,
    parameter int PC_STEP = 4
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic [31:0]     instr,
    input  logic [XLEN-1:0] pc,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    input  logic [XLEN-1:0] imm,
    output logic            branch,
    output logic            mem_read,
    output logic            memto_reg,
    output logic            mem_write,
    output logic            alu_src,
    output logic            reg_write,
    output logic [1:0]      alu_op,
    output logic            cmp_func,
    output logic [XLEN-1:0] alu_result,
    output logic            zero,
    output logic            bigger,
    output logic [XLEN-1:0] pc_plus4,
    output logic [XLEN-1:0] branch_target,
    output logic            taken,
    output logic [XLEN-1:0] next_pc
);

    typedef enum logic [1:0] {
        ALU_ADD = 2'b00,
        ALU_SUB = 2'b01,
        ALU_AND = 2'b10,
        ALU_OR  = 2'b11
    } alu_op_e;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    typedef struct packed {
        logic            branch;
        logic            mem_read;
        logic            memto_reg;
        logic            mem_write;
        logic            alu_src;
        logic            reg_write;
        logic [1:0]      alu_op;
        logic            cmp_func;
        logic [XLEN-1:0] alu_result;
        logic            zero;
        logic            bigger;
        logic [XLEN-1:0] pc_plus4;
        logic [XLEN-1:0] branch_target;
        logic            taken;
        logic [XLEN-1:0] next_pc;
    } stage_t;

    logic [6:0] opcode;
    logic [2:0] funct3;
    assign opcode = instr[6:0];
    assign funct3 = instr[14:12];

    logic    dec_branch, dec_mem_read, dec_memto_reg, dec_mem_write;
    logic    dec_alu_src, dec_reg_write, dec_cmp_func, dec_cond_inv;
    alu_op_e dec_alu_op;

    always_comb begin
        // NOTE: every decode signal is defaulted first so no opcode/funct3 path can infer a latch.
        dec_branch    = 1'b0;
        dec_mem_read  = 1'b0;
        dec_memto_reg = 1'b0;
        dec_mem_write = 1'b0;
        dec_alu_src   = 1'b0;
        dec_reg_write = 1'b0;
        dec_cmp_func  = 1'b0;
        dec_cond_inv  = 1'b0;
        dec_alu_op    = ALU_ADD;
        case (opcode)
            OP_R, OP_I: begin
                dec_reg_write = 1'b1;
                dec_alu_src   = (opcode == OP_I);
                case (funct3)
                    3'b000:  dec_alu_op = (opcode == OP_R && instr[30]) ? ALU_SUB : ALU_ADD;
                    3'b111:  dec_alu_op = ALU_AND;
                    3'b110:  dec_alu_op = ALU_OR;
                    default: dec_alu_op = ALU_ADD;
                endcase
            end
            OP_LOAD: begin
                dec_mem_read  = 1'b1;
                dec_memto_reg = 1'b1;
                dec_reg_write = 1'b1;
                dec_alu_src   = 1'b1;
            end
            OP_STORE: begin
                dec_mem_write = 1'b1;
                dec_alu_src   = 1'b1;
            end
            OP_BRANCH: begin
                dec_alu_op = ALU_SUB;
                case (funct3)
                    3'b000: dec_branch = 1'b1;
                    3'b100: begin
                        dec_branch   = 1'b1;
                        dec_cmp_func = 1'b1;
                    end
`ifdef BRANCH_EXT_EN
                    3'b001: begin
                        dec_branch   = 1'b1;
                        dec_cond_inv = 1'b1;
                    end
                    3'b101: begin
                        dec_branch   = 1'b1;
                        dec_cmp_func = 1'b1;
                        dec_cond_inv = 1'b1;
                    end
`endif
                    default: dec_branch = 1'b0;
                endcase
            end
            default: ;
        endcase
    end

    logic [XLEN-1:0] op1, alu_res;
    logic            alu_zero, alu_bigger, br_cond, br_taken;
    logic [XLEN-1:0] seq_pc, tgt_pc;

    assign op1 = dec_alu_src ? imm : rs2_data;

    always_comb begin
        alu_res = '0;
        case (dec_alu_op)
            ALU_ADD: alu_res = rs1_data + op1;
            ALU_SUB: alu_res = rs1_data - op1;
            ALU_AND: alu_res = rs1_data & op1;
            ALU_OR:  alu_res = rs1_data | op1;
            default: alu_res = '0;
        endcase
    end

    assign alu_zero   = (alu_res == '0);
    assign alu_bigger = ($signed(rs1_data) < $signed(op1));
    // Branch immediate arrives pre-shifted right by one; restore the byte offset here.
    assign seq_pc     = pc + XLEN'(PC_STEP);
    assign tgt_pc     = pc + {imm[XLEN-2:0], 1'b0};
    assign br_cond    = (dec_cmp_func ? alu_bigger : alu_zero) ^ dec_cond_inv;
    assign br_taken   = dec_branch & br_cond;

    stage_t stage_d, stage_q;

    always_comb begin
        stage_d.branch        = dec_branch;
        stage_d.mem_read      = dec_mem_read;
        stage_d.memto_reg     = dec_memto_reg;
        stage_d.mem_write     = dec_mem_write;
        stage_d.alu_src       = dec_alu_src;
        stage_d.reg_write     = dec_reg_write;
        stage_d.alu_op        = dec_alu_op;
        stage_d.cmp_func      = dec_cmp_func;
        stage_d.alu_result    = alu_res;
        stage_d.zero          = alu_zero;
        stage_d.bigger        = alu_bigger;
        stage_d.pc_plus4      = seq_pc;
        stage_d.branch_target = tgt_pc;
        stage_d.taken         = br_taken;
        stage_d.next_pc       = br_taken ? tgt_pc : seq_pc;
    end

    // NOTE: sequential state uses non-blocking assignment so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            stage_q <= '0;
        end else begin
            stage_q <= stage_d;
        end
    end

    assign branch        = stage_q.branch;
    assign mem_read      = stage_q.mem_read;
    assign memto_reg     = stage_q.memto_reg;
    assign mem_write     = stage_q.mem_write;
    assign alu_src       = stage_q.alu_src;
    assign reg_write     = stage_q.reg_write;
    assign alu_op        = stage_q.alu_op;
    assign cmp_func      = stage_q.cmp_func;
    assign alu_result    = stage_q.alu_result;
    assign zero          = stage_q.zero;
    assign bigger        = stage_q.bigger;
    assign pc_plus4      = stage_q.pc_plus4;
    assign branch_target = stage_q.branch_target;
    assign taken         = stage_q.taken;
    assign next_pc       = stage_q.next_pc;

    // Instruction fields this slice does not decode (rd, rs1/rs2 indices, upper funct7 bits).
    logic unused_bits;
    assign unused_bits = ^{instr[31], instr[29:15], instr[11:7], imm[XLEN-1]};

endmodule

// File: tb/tb_rv_exec_ctrl_unit.sv
// Self-checking bench for rv_exec_ctrl_unit: directed cases plus random instructions vs a behavioural model.
module tb_rv_exec_ctrl_unit;

    logic        clk;
    logic        rstn;
    logic [31:0] instr, pc, rs1_data, rs2_data, imm;
    logic        branch, mem_read, memto_reg, mem_write, alu_src, reg_write, cmp_func;
    logic [1:0]  alu_op;
    logic [31:0] alu_result, pc_plus4, branch_target, next_pc;
    logic        zero, bigger, taken;

    int n_checks = 0;
    int n_fail   = 0;

    rv_exec_ctrl_unit #(.XLEN(32), .PC_STEP(4)) dut (
        .clk(clk), .rstn(rstn), .instr(instr), .pc(pc),
        .rs1_data(rs1_data), .rs2_data(rs2_data), .imm(imm),
        .branch(branch), .mem_read(mem_read), .memto_reg(memto_reg),
        .mem_write(mem_write), .alu_src(alu_src), .reg_write(reg_write),
        .alu_op(alu_op), .cmp_func(cmp_func), .alu_result(alu_result),
        .zero(zero), .bigger(bigger), .pc_plus4(pc_plus4),
        .branch_target(branch_target), .taken(taken), .next_pc(next_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        branch, mem_read, memto_reg, mem_write, alu_src, reg_write, cmp_func;
        logic [1:0]  alu_op;
        logic [31:0] alu_result, pc_plus4, branch_target, next_pc;
        logic        zero, bigger, taken;
    } exp_t;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference: instruction semantics stated directly (equality / signed order for branches).
    function automatic exp_t model(input logic [31:0] ins, input logic [31:0] p,
                                   input logic [31:0] a, input logic [31:0] b,
                                   input logic [31:0] im);
        exp_t e;
        logic [6:0]  opc = ins[6:0];
        logic [2:0]  f3  = ins[14:12];
        logic [31:0] rhs;
        logic        cond = 1'b0;
        e = '{default: '0};
        if (opc == 7'h33 || opc == 7'h13) begin
            e.reg_write = 1;
            e.alu_src   = (opc == 7'h13);
            if (f3 == 3'd7)      e.alu_op = 2'd2;
            else if (f3 == 3'd6) e.alu_op = 2'd3;
            else if (f3 == 3'd0 && opc == 7'h33 && ins[30]) e.alu_op = 2'd1;
        end else if (opc == 7'h03) begin
            e.mem_read = 1; e.memto_reg = 1; e.reg_write = 1; e.alu_src = 1;
        end else if (opc == 7'h23) begin
            e.mem_write = 1; e.alu_src = 1;
        end else if (opc == 7'h63) begin
            e.alu_op = 2'd1;
            case (f3)
                3'd0: begin e.branch = 1; cond = (a == b); end
                3'd4: begin e.branch = 1; e.cmp_func = 1; cond = ($signed(a) < $signed(b)); end
`ifdef BRANCH_EXT_EN
                3'd1: begin e.branch = 1; cond = (a != b); end
                3'd5: begin e.branch = 1; e.cmp_func = 1; cond = ($signed(a) >= $signed(b)); end
`endif
                default: ;
            endcase
        end
        rhs = e.alu_src ? im : b;
        case (e.alu_op)
            2'd0: e.alu_result = a + rhs;
            2'd1: e.alu_result = a - rhs;
            2'd2: e.alu_result = a & rhs;
            default: e.alu_result = a | rhs;
        endcase
        e.zero          = (e.alu_result == 0);
        e.bigger        = ($signed(a) < $signed(rhs));
        e.pc_plus4      = p + 4;
        e.branch_target = p + im * 2;
        e.taken         = e.branch && cond;
        e.next_pc       = e.taken ? e.branch_target : e.pc_plus4;
        return e;
    endfunction

    // Expectation is formed from the inputs present before the edge; outputs sampled 1 time unit after it.
    task automatic cycle_check(input string tag);
        exp_t e;
        if (rstn) e = model(instr, pc, rs1_data, rs2_data, imm);
        else      e = '{default: '0};
        @(posedge clk);
        #1;
        check({tag, ".branch"},     {31'd0, branch},    {31'd0, e.branch});
        check({tag, ".mem_read"},   {31'd0, mem_read},  {31'd0, e.mem_read});
        check({tag, ".memto_reg"},  {31'd0, memto_reg}, {31'd0, e.memto_reg});
        check({tag, ".mem_write"},  {31'd0, mem_write}, {31'd0, e.mem_write});
        check({tag, ".alu_src"},    {31'd0, alu_src},   {31'd0, e.alu_src});
        check({tag, ".reg_write"},  {31'd0, reg_write}, {31'd0, e.reg_write});
        check({tag, ".alu_op"},     {30'd0, alu_op},    {30'd0, e.alu_op});
        check({tag, ".cmp_func"},   {31'd0, cmp_func},  {31'd0, e.cmp_func});
        check({tag, ".alu_result"}, alu_result,         e.alu_result);
        check({tag, ".zero"},       {31'd0, zero},      {31'd0, e.zero});
        check({tag, ".bigger"},     {31'd0, bigger},    {31'd0, e.bigger});
        check({tag, ".pc_plus4"},   pc_plus4,           e.pc_plus4);
        check({tag, ".br_target"},  branch_target,      e.branch_target);
        check({tag, ".taken"},      {31'd0, taken},     {31'd0, e.taken});
        check({tag, ".next_pc"},    next_pc,            e.next_pc);
    endtask

    task automatic drive(input logic [31:0] i, input logic [31:0] p,
                         input logic [31:0] a, input logic [31:0] b, input logic [31:0] im);
        instr = i; pc = p; rs1_data = a; rs2_data = b; imm = im;
    endtask

    task automatic drive_random();
        logic [6:0]  opcs [6] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h63};
        logic [31:0] w = $urandom;
        logic [31:0] a = $urandom;
        logic [31:0] b;
        int          k = $urandom_range(0, 6);
        if (k < 6) w[6:0] = opcs[k];
        case ($urandom_range(0, 3))
            0:       b = a;
            1:       b = $urandom_range(0, 15);
            default: b = $urandom;
        endcase
        if ($urandom_range(0, 3) == 0) a = $urandom_range(0, 15);
        drive(w, $urandom & 32'hFFFF_FFFC, a, b, $urandom);
    endtask

    initial begin
        rstn = 1'b0;
        drive_random();
        cycle_check("rst0");
        drive_random();
        cycle_check("rst1");

        // First instruction after release: visible one edge later.
        rstn = 1'b1;
        drive(32'h40208033, 32'h1000, 32'd5, 32'd7, 32'd0);
        cycle_check("sub");
        check("sub_result", alu_result, 32'hFFFF_FFFE);
        check("sub_alu_op", {30'd0, alu_op}, 32'd1);

        drive(32'h0000A083, 32'h1004, 32'h10, 32'h0, 32'd4);
        cycle_check("lw");
        check("lw_result", alu_result, 32'h14);
        drive(32'h0020A223, 32'h1008, 32'h20, 32'h55, 32'd4);
        cycle_check("sw");
        check("sw_mem_write", {31'd0, mem_write}, 32'd1);

        drive(32'h00208463, 32'h3000, 32'd9, 32'd9, 32'd4);
        cycle_check("beq_t");
        check("beq_t_next_pc", next_pc, 32'h3008);
        drive(32'h00208463, 32'h3000, 32'd9, 32'd8, 32'd4);
        cycle_check("beq_nt");
        check("beq_nt_next_pc", next_pc, 32'h3004);

        drive(32'h0020C463, 32'h4000, 32'hFFFF_FFFF, 32'd1, 32'd8);
        cycle_check("blt_t");
        check("blt_t_taken", {31'd0, taken}, 32'd1);
        drive(32'h0020C463, 32'h4000, 32'd1, 32'hFFFF_FFFF, 32'd8);
        cycle_check("blt_nt");
        check("blt_nt_taken", {31'd0, taken}, 32'd0);

        drive(32'hFFFF_FFFF, 32'h5000, 32'd3, 32'd4, 32'd12);
        cycle_check("illegal");
        check("illegal_next_pc", next_pc, 32'h5004);

        drive(32'h00209463, 32'h6000, 32'd3, 32'd4, 32'd16);
        cycle_check("bne");
`ifdef BRANCH_EXT_EN
        check("bne_taken", {31'd0, taken}, 32'd1);
`else
        check("bne_taken", {31'd0, taken}, 32'd0);
`endif
        drive(32'h0020D463, 32'h6000, 32'd4, 32'd3, 32'd16);
        cycle_check("bge");

        // Wrap-around of both PC adders.
        drive(32'h00208463, 32'hFFFF_FFFC, 32'd1, 32'd1, 32'h4000_0002);
        cycle_check("pc_wrap");

        // Reset mid-stream discards the in-flight instruction.
        drive(32'h0000A083, 32'h7000, 32'h100, 32'h0, 32'd4);
        rstn = 1'b0;
        cycle_check("rst_mid");
        rstn = 1'b1;
        drive(32'h0000A083, 32'h7000, 32'h100, 32'h0, 32'd4);
        cycle_check("post_rst");

        for (int i = 0; i < 400; i++) begin
            drive_random();
            if (i % 97 == 50) rstn = 1'b0;
            else              rstn = 1'b1;
            cycle_check("rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
